// File: rtl/sample_pkg.sv
// sample_pkg: shared definitions for the sample window collector.
//   DEF_DATAWIDTH / DEF_NSAMP : default sample width and samples per frame
//   SLOT_W                    : slot index width, clog2(DEF_NSAMP)
//   state_t, FILL, HOLD       : collector FSM encoding
//   frame_slot()              : extract slot k from a flat frame
package sample_pkg;

    localparam int unsigned DEF_DATAWIDTH = 16;
    localparam int unsigned DEF_NSAMP     = 8;
    localparam int unsigned SLOT_W        = $clog2(DEF_NSAMP);

    typedef logic [0:0] state_t;
    localparam state_t FILL = 1'b0;
    localparam state_t HOLD = 1'b1;

    function automatic logic [DEF_DATAWIDTH-1:0] frame_slot(
        input logic [DEF_NSAMP*DEF_DATAWIDTH-1:0] frame,
        input int unsigned                        k
    );
        return frame[DEF_DATAWIDTH*k +: DEF_DATAWIDTH];
    endfunction

endpackage

// File: rtl/sample_window_buf.sv
// sample_window_buf: NSAMP-entry collect buffer with write count and full flag.
// Build option: SAMPLE_WINDOW_SLIDING_EN turns the buffer into a shift register
// (new sample enters slot NSAMP-1, slot 0 drops) that stays primed once filled.
// Ports:
//   clk, rst   : clock, async active-low reset
//   push       : accept push_data this cycle
//   push_data  : incoming sample
//   drain      : buffer contents handed off this cycle, restart at slot 0
//   window     : buffer contents including this cycle's push (flat, slot 0 lsb)
//   completes  : this cycle's push completes a window
//   full       : block mode: all slots written and not yet drained;
//                sliding mode: buffer primed
module sample_window_buf
    import sample_pkg::*;
#(
    parameter int unsigned DATAWIDTH = DEF_DATAWIDTH,
    parameter int unsigned NSAMP     = DEF_NSAMP
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [DATAWIDTH-1:0]       push_data,
    input  logic                       drain,
    output logic [NSAMP*DATAWIDTH-1:0] window,
    output logic                       completes,
    output logic                       full
);

    localparam int unsigned CW = $clog2(NSAMP + 1);

    logic [CW-1:0]              cnt_q, cnt_d;
    logic [NSAMP*DATAWIDTH-1:0] mem_q, mem_d;

`ifdef SAMPLE_WINDOW_SLIDING_EN
    // drain has no meaning for a moving window: the history is always kept.
    logic unused_drain;
    assign unused_drain = drain;

    always_comb begin
        mem_d = mem_q;
        cnt_d = cnt_q;
        if (push) begin
            mem_d = {push_data, mem_q[NSAMP*DATAWIDTH-1:DATAWIDTH]};
            if (cnt_q != CW'(NSAMP)) cnt_d = cnt_q + CW'(1);
        end
    end

    assign completes = push && (cnt_q >= CW'(NSAMP - 1));
`else
    always_comb begin
        mem_d = mem_q;
        cnt_d = cnt_q;
        if (push) begin
            for (int k = 0; k < NSAMP; k++) begin
                if (cnt_q == CW'(k)) mem_d[k*DATAWIDTH +: DATAWIDTH] = push_data;
            end
            cnt_d = cnt_q + CW'(1);
        end
        // Drain wins over the increment so the window-completing push restarts at 0.
        if (drain) cnt_d = '0;
    end

    assign completes = push && (cnt_q == CW'(NSAMP - 1));
`endif

    assign window = mem_d;
    assign full   = (cnt_q == CW'(NSAMP));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            mem_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/sample_window_collector.sv
// sample_window_collector: groups a serial valid/ready sample stream into
// NSAMP-sample frames presented in parallel with their own valid/ready.
// Double-buffered: the collect buffer fills while the output register holds
// the previous frame.
// Build option: SAMPLE_WINDOW_SLIDING_EN selects moving-window frames (one new
// frame per accepted sample once primed); default is non-overlapping blocks.
// Ports:
//   clk, rst             : clock, async active-low reset
//   in_data, in_valid    : sample input
//   in_ready             : sample can be accepted
//   out_frame, out_valid : registered frame, slot k at [DATAWIDTH*k +: DATAWIDTH]
//   out_ready            : downstream consumes the frame
//   frame_cnt            : frames loaded into the output register, wraps
module sample_window_collector
    import sample_pkg::*;
#(
    parameter int unsigned DATAWIDTH = DEF_DATAWIDTH,
    parameter int unsigned NSAMP     = DEF_NSAMP,
    parameter int unsigned CNTWIDTH  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATAWIDTH-1:0]       in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [NSAMP*DATAWIDTH-1:0] out_frame,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CNTWIDTH-1:0]        frame_cnt
);

    state_t                     state_q, state_d;
    logic [NSAMP*DATAWIDTH-1:0] frame_q, frame_d;
    logic                       valid_q, valid_d;
    logic [CNTWIDTH-1:0]        cnt_q, cnt_d;

    logic                       accept, consume, drain;
    logic [NSAMP*DATAWIDTH-1:0] window;
    logic                       completes, buf_full;

`ifdef SAMPLE_WINDOW_SLIDING_EN
    // Once primed every accept emits a frame, so accept only when the output
    // register will be free at the next edge.
    assign in_ready = rst && (state_q == FILL) && !(buf_full && valid_q && !out_ready);
`else
    assign in_ready = rst && (state_q == FILL);
`endif

    assign accept  = in_valid && in_ready;
    assign consume = valid_q && out_ready;

    sample_window_buf #(
        .DATAWIDTH (DATAWIDTH),
        .NSAMP     (NSAMP)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (accept),
        .push_data (in_data),
        .drain     (drain),
        .window    (window),
        .completes (completes),
        .full      (buf_full)
    );

    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        drain   = 1'b0;
        case (state_q)
            FILL: begin
                if (completes) begin
                    if (!valid_q || consume) begin
                        frame_d = window;
                        valid_d = 1'b1;
                        cnt_d   = cnt_q + CNTWIDTH'(1);
                        drain   = 1'b1;
                    end else begin
                        state_d = HOLD;
                    end
                end else if (consume) begin
                    valid_d = 1'b0;
                end
            end
            HOLD: begin
                // No push in HOLD, so window is exactly the held buffer.
                if (consume) begin
                    frame_d = window;
                    cnt_d   = cnt_q + CNTWIDTH'(1);
                    drain   = 1'b1;
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FILL;
            frame_q <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_frame = frame_q;
    assign out_valid = valid_q;
    assign frame_cnt = cnt_q;

endmodule

// File: tb/tb_sample_window_collector.sv
// Self-checking bench for sample_window_collector (directed vectors).
// Block-window tests run by default; with SAMPLE_WINDOW_SLIDING_EN defined the
// moving-window test runs instead.
module tb_sample_window_collector;
    import sample_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic [15:0]  in_data;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] out_frame;
    logic         out_valid;
    logic         out_ready;
    logic [15:0]  frame_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    sample_window_collector #(
        .DATAWIDTH (16),
        .NSAMP     (8),
        .CNTWIDTH  (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_frame (out_frame),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, got no finish, need finish");
        $fatal(1, "watchdog");
    end

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] mk_frame(input int base);
        logic [127:0] f;
        for (int k = 0; k < 8; k++) f[16*k +: 16] = 16'(base + k);
        return f;
    endfunction

    task automatic apply_reset();
        rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        cyc(); cyc();
        rst = 1'b1;
        cyc();
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b1; in_data = 16'h5555; out_ready = 1'b0;
        cyc(); cyc();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b need 0", out_valid); else n_pass++;
        n_checks++; if (out_frame !== 128'd0) $display("FAIL reset_frame: got %h need 0", out_frame); else n_pass++;
        n_checks++; if (frame_cnt !== 16'd0) $display("FAIL reset_cnt: got %0d need 0", frame_cnt); else n_pass++;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b need 0", in_ready); else n_pass++;
        in_valid = 1'b0;
        rst = 1'b1;
        cyc();
        n_checks++; if (in_ready !== 1'b1) $display("FAIL post_reset_in_ready: got %b need 1", in_ready); else n_pass++;
    endtask

    task automatic test_basic();
        apply_reset();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            n_checks++; if (in_ready !== 1'b1) $display("FAIL basic_in_ready[%0d]: got %b need 1", i, in_ready); else n_pass++;
            in_valid = 1'b1; in_data = 16'(i);
            cyc();
            if (i == 7) begin
                n_checks++; if (out_valid !== 1'b0) $display("FAIL basic_early_valid: got %b need 0", out_valid); else n_pass++;
            end
        end
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1) $display("FAIL basic_valid: got %b need 1", out_valid); else n_pass++;
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (frame_slot(out_frame, k) !== 16'(k + 1))
                $display("FAIL basic_slot%0d: got %0d need %0d", k, frame_slot(out_frame, k), k + 1);
            else n_pass++;
        end
        n_checks++; if (frame_cnt !== 16'd1) $display("FAIL basic_cnt: got %0d need 1", frame_cnt); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL basic_in_ready_end: got %b need 1", in_ready); else n_pass++;
        cyc();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL basic_consumed: got %b need 0", out_valid); else n_pass++;
    endtask

    task automatic test_hold();
        apply_reset();
        out_ready = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            n_checks++; if (in_ready !== 1'b1) $display("FAIL hold_in_ready[%0d]: got %b need 1", i, in_ready); else n_pass++;
            in_valid = 1'b1; in_data = 16'(i);
            cyc();
            if (i >= 8) begin
                n_checks++;
                if (out_frame !== mk_frame(1) || out_valid !== 1'b1)
                    $display("FAIL hold_stable[%0d]: got v=%b %h need v=1 %h", i, out_valid, out_frame, mk_frame(1));
                else n_pass++;
            end
        end
        in_valid = 1'b0;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL hold_in_ready_full: got %b need 0", in_ready); else n_pass++;
        n_checks++; if (frame_cnt !== 16'd1) $display("FAIL hold_cnt1: got %0d need 1", frame_cnt); else n_pass++;
        cyc();
        n_checks++; if (out_frame !== mk_frame(1)) $display("FAIL hold_still: got %h need %h", out_frame, mk_frame(1)); else n_pass++;
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        n_checks++; if (out_frame !== mk_frame(9)) $display("FAIL hold_release_frame: got %h need %h", out_frame, mk_frame(9)); else n_pass++;
        n_checks++; if (out_valid !== 1'b1) $display("FAIL hold_release_valid: got %b need 1", out_valid); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL hold_release_in_ready: got %b need 1", in_ready); else n_pass++;
        n_checks++; if (frame_cnt !== 16'd2) $display("FAIL hold_release_cnt: got %0d need 2", frame_cnt); else n_pass++;
        out_ready = 1'b1;
        cyc();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL hold_drained: got %b need 0", out_valid); else n_pass++;
    endtask

    task automatic test_back_to_back();
        apply_reset();
        out_ready = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            in_valid = 1'b1; in_data = 16'(i);
            out_ready = (i == 16);
            cyc();
            if (i >= 8) begin
                n_checks++; if (out_valid !== 1'b1) $display("FAIL b2b_valid_gap[%0d]: got %b need 1", i, out_valid); else n_pass++;
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        n_checks++; if (out_frame !== mk_frame(9)) $display("FAIL b2b_frame: got %h need %h", out_frame, mk_frame(9)); else n_pass++;
        n_checks++; if (frame_cnt !== 16'd2) $display("FAIL b2b_cnt: got %0d need 2", frame_cnt); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL b2b_in_ready: got %b need 1", in_ready); else n_pass++;
        out_ready = 1'b1;
        cyc();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL b2b_drained: got %b need 0", out_valid); else n_pass++;
    endtask

    task automatic test_gaps();
        int nf = 0, nxt = 1, c = 0;
        logic acc;
        apply_reset();
        out_ready = 1'b1;
        while (nf < 3 && c < 200) begin
            if (nxt <= 24) begin
                in_valid = ((c % 5) != 1) && ((c % 7) != 3);
                in_data  = 16'(nxt);
            end else begin
                in_valid = 1'b0;
            end
            acc = in_valid && in_ready;
            cyc();
            if (acc) nxt++;
            if (out_valid) begin
                n_checks++;
                if (out_frame !== mk_frame(nf * 8 + 1))
                    $display("FAIL gaps_frame%0d: got %h need %h", nf, out_frame, mk_frame(nf * 8 + 1));
                else n_pass++;
                nf++;
            end
            c++;
        end
        in_valid = 1'b0;
        n_checks++; if (nf != 3) $display("FAIL gaps_nframes: got %0d need 3", nf); else n_pass++;
        n_checks++; if (frame_cnt !== 16'd3) $display("FAIL gaps_cnt: got %0d need 3", frame_cnt); else n_pass++;
    endtask

    task automatic test_mid_reset();
        apply_reset();
        out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            in_valid = 1'b1; in_data = 16'(i);
            cyc();
        end
        rst = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL midrst_in_ready: got %b need 0", in_ready); else n_pass++;
        cyc();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL midrst_valid: got %b need 0", out_valid); else n_pass++;
        rst = 1'b1;
        out_ready = 1'b1;
        for (int i = 100; i <= 107; i++) begin
            in_valid = 1'b1; in_data = 16'(i);
            cyc();
            if (i < 107) begin
                n_checks++; if (out_valid !== 1'b0) $display("FAIL midrst_early[%0d]: got %b need 0", i, out_valid); else n_pass++;
            end
        end
        in_valid = 1'b0;
        n_checks++; if (out_frame !== mk_frame(100) || out_valid !== 1'b1)
            $display("FAIL midrst_frame: got v=%b %h need v=1 %h", out_valid, out_frame, mk_frame(100));
        else n_pass++;
        n_checks++; if (frame_cnt !== 16'd1) $display("FAIL midrst_cnt: got %0d need 1", frame_cnt); else n_pass++;
    endtask

    task automatic test_sliding();
        apply_reset();
        out_ready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            n_checks++; if (in_ready !== 1'b1) $display("FAIL slide_in_ready[%0d]: got %b need 1", i, in_ready); else n_pass++;
            in_valid = 1'b1; in_data = 16'(i);
            cyc();
            if (i >= 8) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_frame !== mk_frame(i - 7))
                    $display("FAIL slide_frame[%0d]: got v=%b %h need v=1 %h", i, out_valid, out_frame, mk_frame(i - 7));
                else n_pass++;
            end
        end
        in_valid = 1'b0;
        n_checks++; if (frame_cnt !== 16'd3) $display("FAIL slide_cnt: got %0d need 3", frame_cnt); else n_pass++;
        // Primed with the frame held: further samples must be refused.
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 16'd11;
        cyc();
        n_checks++; if (in_ready !== 1'b0) $display("FAIL slide_backpressure: got %b need 0", in_ready); else n_pass++;
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        test_reset();
`ifdef SAMPLE_WINDOW_SLIDING_EN
        test_sliding();
`else
        test_basic();
        test_hold();
        test_back_to_back();
        test_gaps();
        test_mid_reset();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
